// File: rtl/spi_sram_target.sv
// spi_sram_target: SPI mode-0 responder that emulates a 23-series serial SRAM
// (READ/WRITE/RDMR/WRMR, sequential mode). SCLK/CE/SI are oversampled in the
// clk domain, and bytes are served through a byte-wide memory port.
module spi_sram_target #(
    parameter int         ADDR_W   = 23,
    parameter logic [7:0] MODE_RST = 8'h40
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              ce,
    input  logic              si,
    output logic              so,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata,
    output logic              active,
    output logic              cmd_err
);

    typedef enum logic [2:0] {
        IDLE, CMD, ADDR, WR_DATA, RD_DATA, RDMR, WRMR, IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ  = 8'h03;
    localparam logic [7:0] CMD_WRITE = 8'h02;
    localparam logic [7:0] CMD_RDMR  = 8'h05;
    localparam logic [7:0] CMD_WRMR  = 8'h01;

    // Synchronisers and edge-detect history.
    logic       sclk_s1, sclk_s2, sclk_d;
    logic       ce_s1, ce_s2;
    logic       si_s1, si_s2;
    logic [1:0] sync_ok;    // becomes all-ones once the synchronisers hold real pin values
    logic       armed;      // a deasserted ce has been seen since reset
    logic       rise, fall;

    // Transaction state.
    state_t            state, state_n;
    logic [2:0]        bit_cnt, bit_cnt_n;
    logic [1:0]        byte_cnt, byte_cnt_n;
    logic [ADDR_W-2:0] sh_in, sh_in_n;
    logic [7:0]        sh_out, sh_out_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              is_read, is_read_n;
    logic [7:0]        pf_buf, pf_buf_n;
    logic [1:0]        rd_wait, rd_wait_n;   // countdown to the first read byte landing
    logic [1:0]        pf_wait, pf_wait_n;   // countdown to the prefetch byte landing
    logic              byte_done, byte_done_n;
    logic              seen_rise, seen_rise_n;
    logic [7:0]        mode_reg, mode_reg_n;
    logic              so_n, mem_we_n, mem_re_n, cmd_err_n;
    logic [ADDR_W-1:0] mem_addr_n;
    logic [7:0]        mem_wdata_n;

    logic [ADDR_W-1:0] shift_word;   // sh_in with the current si bit appended
    logic [7:0]        byte_in;

    assign rise       = sclk_s2 & ~sclk_d;
    assign fall       = ~sclk_s2 & sclk_d;
    assign active     = armed & ~ce_s2;
    assign shift_word = {sh_in, si_s2};
    assign byte_in    = shift_word[7:0];

    // Double-flop the SPI pins and track when a fresh transaction may start.
    always_ff @(posedge clk) begin
        // NOTE: every flop here uses <= so all registers update from pre-edge values.
        if (reset) begin
            sclk_s1 <= 1'b0;
            sclk_s2 <= 1'b0;
            sclk_d  <= 1'b0;
            ce_s1   <= 1'b1;
            ce_s2   <= 1'b1;
            si_s1   <= 1'b0;
            si_s2   <= 1'b0;
            sync_ok <= 2'b00;
            armed   <= 1'b0;
        end else begin
            sclk_s1 <= sclk;
            sclk_s2 <= sclk_s1;
            sclk_d  <= sclk_s2;
            ce_s1   <= ce;
            ce_s2   <= ce_s1;
            si_s1   <= si;
            si_s2   <= si_s1;
            sync_ok <= {sync_ok[0], 1'b1};
            armed   <= armed | (sync_ok[1] & ce_s2);
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            sh_in     <= '0;
            sh_out    <= '0;
            addr      <= '0;
            is_read   <= 1'b0;
            pf_buf    <= '0;
            rd_wait   <= '0;
            pf_wait   <= '0;
            byte_done <= 1'b0;
            seen_rise <= 1'b0;
            mode_reg  <= MODE_RST;
            so        <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            cmd_err   <= 1'b0;
        end else begin
            state     <= state_n;
            bit_cnt   <= bit_cnt_n;
            byte_cnt  <= byte_cnt_n;
            sh_in     <= sh_in_n;
            sh_out    <= sh_out_n;
            addr      <= addr_n;
            is_read   <= is_read_n;
            pf_buf    <= pf_buf_n;
            rd_wait   <= rd_wait_n;
            pf_wait   <= pf_wait_n;
            byte_done <= byte_done_n;
            seen_rise <= seen_rise_n;
            mode_reg  <= mode_reg_n;
            so        <= so_n;
            mem_addr  <= mem_addr_n;
            mem_wdata <= mem_wdata_n;
            mem_we    <= mem_we_n;
            mem_re    <= mem_re_n;
            cmd_err   <= cmd_err_n;
        end
    end

    // Next-state, shifter and strobe logic.
    always_comb begin
        // NOTE: every signal gets its hold/idle value first so no path infers a latch.
        state_n     = state;
        bit_cnt_n   = bit_cnt;
        byte_cnt_n  = byte_cnt;
        sh_in_n     = sh_in;
        sh_out_n    = sh_out;
        addr_n      = addr;
        is_read_n   = is_read;
        pf_buf_n    = pf_buf;
        rd_wait_n   = rd_wait;
        pf_wait_n   = pf_wait;
        byte_done_n = byte_done;
        seen_rise_n = seen_rise;
        mode_reg_n  = mode_reg;
        so_n        = so;
        mem_addr_n  = mem_addr;
        mem_wdata_n = mem_wdata;
        mem_we_n    = 1'b0;
        mem_re_n    = 1'b0;
        cmd_err_n   = 1'b0;

        if (!active) begin
            // Deselected (or not yet re-armed after reset): drop everything in flight.
            state_n     = IDLE;
            bit_cnt_n   = '0;
            byte_cnt_n  = '0;
            rd_wait_n   = '0;
            pf_wait_n   = '0;
            byte_done_n = 1'b0;
            seen_rise_n = 1'b0;
            so_n        = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    so_n    = 1'b0;
                    state_n = CMD;
                end
                CMD: begin
                    so_n = 1'b0;
                    if (rise) begin
                        sh_in_n   = shift_word[ADDR_W-2:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt_n  = '0;
                            seen_rise_n = 1'b0;
                            byte_done_n = 1'b0;
                            case (byte_in)
                                CMD_READ:  begin state_n = ADDR; is_read_n = 1'b1; end
                                CMD_WRITE: begin state_n = ADDR; is_read_n = 1'b0; end
                                CMD_RDMR: begin
                                    state_n  = RDMR;
                                    sh_out_n = mode_reg;
                                    so_n     = mode_reg[7];
                                end
                                CMD_WRMR:  state_n = WRMR;
                                default: begin
                                    state_n   = IGNORE;
                                    cmd_err_n = 1'b1;
                                end
                            endcase
                        end
                    end
                end
                ADDR: begin
                    so_n = 1'b0;
                    if (rise) begin
                        sh_in_n   = shift_word[ADDR_W-2:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            byte_cnt_n = byte_cnt + 2'd1;
                            if (byte_cnt == 2'd2) begin
                                addr_n = shift_word;
                                if (is_read) begin
                                    state_n    = RD_DATA;
                                    mem_re_n   = 1'b1;
                                    mem_addr_n = shift_word;
                                    rd_wait_n  = 2'd2;
                                end else begin
                                    state_n = WR_DATA;
                                end
                            end
                        end
                    end
                end
                WR_DATA: begin
                    so_n = 1'b0;
                    if (rise) begin
                        sh_in_n   = shift_word[ADDR_W-2:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mem_we_n    = 1'b1;
                            mem_addr_n  = addr;
                            mem_wdata_n = byte_in;
                            addr_n      = addr + ADDR_W'(1);
                        end
                    end
                end
                RD_DATA: begin
                    if (pf_wait == 2'd2) begin
                        pf_wait_n = 2'd1;
                    end else if (pf_wait == 2'd1) begin
                        pf_wait_n = 2'd0;
                        pf_buf_n  = mem_rdata;
                    end
                    if (rd_wait == 2'd2) begin
                        rd_wait_n = 2'd1;
                    end else if (rd_wait == 2'd1) begin
                        rd_wait_n  = 2'd0;
                        sh_out_n   = mem_rdata;
                        so_n       = mem_rdata[7];
                        mem_re_n   = 1'b1;
                        mem_addr_n = addr + ADDR_W'(1);
                        pf_wait_n  = 2'd2;
                    end
                    if (rise) begin
                        seen_rise_n = 1'b1;
                        bit_cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_n = 1'b1;
                    end else if (fall) begin
                        if (byte_done) begin
                            byte_done_n = 1'b0;
                            sh_out_n    = pf_buf;
                            so_n        = pf_buf[7];
                            addr_n      = addr + ADDR_W'(1);
                            mem_re_n    = 1'b1;
                            mem_addr_n  = addr + ADDR_W'(2);
                            pf_wait_n   = 2'd2;
                        end else if (seen_rise) begin
                            sh_out_n = {sh_out[6:0], 1'b0};
                            so_n     = sh_out[6];
                        end
                    end
                end
                RDMR: begin
                    if (rise) begin
                        seen_rise_n = 1'b1;
                        bit_cnt_n   = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) byte_done_n = 1'b1;
                    end else if (fall) begin
                        if (byte_done) begin
                            byte_done_n = 1'b0;
                            sh_out_n    = mode_reg;
                            so_n        = mode_reg[7];
                        end else if (seen_rise) begin
                            sh_out_n = {sh_out[6:0], 1'b0};
                            so_n     = sh_out[6];
                        end
                    end
                end
                WRMR: begin
                    so_n = 1'b0;
                    if (rise) begin
                        sh_in_n   = shift_word[ADDR_W-2:0];
                        bit_cnt_n = bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            mode_reg_n = byte_in;
                            state_n    = IGNORE;
                        end
                    end
                end
                default: begin
                    so_n = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_sram_target.sv
// tb_spi_sram_target: directed bench for spi_sram_target. A bit-banged SPI
// master drives the pins; a one-cycle-latency memory model returns
// addr[7:0]^FF on reads, and strobes are logged at the falling clk edge.
module tb_spi_sram_target;

    logic        clk = 1'b0;
    logic        reset;
    logic        sclk, ce, si;
    logic        so;
    logic [22:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we, mem_re;
    logic [7:0]  mem_rdata = 8'h00;
    logic        active, cmd_err;

    int          n_checks = 0;
    int          n_bad    = 0;
    int          err_cnt  = 0;
    int          both_cnt = 0;
    logic [31:0] re_q[$];
    logic [31:0] we_q[$];
    logic [7:0]  rx;

    always #5 clk = ~clk;

    spi_sram_target #(.ADDR_W(23), .MODE_RST(8'h40)) dut (
        .clk       (clk),
        .reset     (reset),
        .sclk      (sclk),
        .ce        (ce),
        .si        (si),
        .so        (so),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .active    (active),
        .cmd_err   (cmd_err)
    );

    // Memory model: read data appears one clk after mem_re.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_addr[7:0] ^ 8'hFF;
    end

    // Strobe logger.
    always @(negedge clk) begin
        if (mem_re) re_q.push_back({9'd0, mem_addr});
        if (mem_we) we_q.push_back({1'b0, mem_addr, mem_wdata});
        if (cmd_err) err_cnt++;
        if (mem_re && mem_we) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_log();
        re_q.delete();
        we_q.delete();
        err_cnt = 0;
    endtask

    task automatic spi_begin();
        ce = 1'b0;
        wait_clk(8);
    endtask

    task automatic spi_end();
        wait_clk(8);
        ce = 1'b1;
        wait_clk(8);
    endtask

    // Shift n bits of tx out MSB first; so is sampled just before each rise.
    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] got);
        got = 8'h00;
        for (int i = 7; i > 7 - n; i--) begin
            si = tx[i];
            wait_clk(8);
            got[i] = so;
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] got);
        spi_bits(tx, 8, got);
    endtask

    function automatic logic [31:0] re_at(input int i);
        return (i < re_q.size()) ? re_q[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic logic [31:0] we_at(input int i);
        return (i < we_q.size()) ? we_q[i] : 32'hFFFF_FFFF;
    endfunction

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        ce    = 1'b1;
        si    = 1'b0;
        wait_clk(4);
        check("rst_so",      {31'd0, so},      32'd0);
        check("rst_we",      {31'd0, mem_we},  32'd0);
        check("rst_re",      {31'd0, mem_re},  32'd0);
        check("rst_active",  {31'd0, active},  32'd0);
        check("rst_cmd_err", {31'd0, cmd_err}, 32'd0);
        check("rst_addr",    {9'd0, mem_addr}, 32'd0);
        check("rst_wdata",   {24'd0, mem_wdata}, 32'd0);
        reset = 1'b0;
        wait_clk(6);

        // 1: WRITE 0x10 <- A5, 3C
        clear_log();
        spi_begin();
        wait_clk(2);
        check("t1_active", {31'd0, active}, 32'd1);
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h10, rx);
        spi_byte(8'hA5, rx); spi_byte(8'h3C, rx);
        spi_end();
        check("t1_we_count", we_q.size(), 32'd2);
        check("t1_we0", we_at(0), {1'b0, 23'h10, 8'hA5});
        check("t1_we1", we_at(1), {1'b0, 23'h11, 8'h3C});
        check("t1_re_count", re_q.size(), 32'd0);
        check("t1_idle_active", {31'd0, active}, 32'd0);

        // 2: READ 0x20, four bytes
        clear_log();
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
        spi_byte(8'h00, rx); check("t2_rx0", {24'd0, rx}, 32'hDF);
        spi_byte(8'h00, rx); check("t2_rx1", {24'd0, rx}, 32'hDE);
        spi_byte(8'h00, rx); check("t2_rx2", {24'd0, rx}, 32'hDD);
        spi_byte(8'h00, rx); check("t2_rx3", {24'd0, rx}, 32'hDC);
        spi_end();
        for (int i = 0; i < 5; i++) check($sformatf("t2_re%0d", i), re_at(i), 32'h20 + i);
        check("t2_we_count", we_q.size(), 32'd0);

        // 3: READ across the top of the address space
        clear_log();
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'h7F, rx); spi_byte(8'hFF, rx); spi_byte(8'hFF, rx);
        spi_byte(8'h00, rx); check("t3_rx0", {24'd0, rx}, 32'h00);
        spi_byte(8'h00, rx); check("t3_rx1", {24'd0, rx}, 32'hFF);
        spi_end();
        check("t3_re0", re_at(0), 32'h7F_FFFF);
        check("t3_re1", re_at(1), 32'h00_0000);

        // 4: partial write byte is dropped, then a full one lands
        clear_log();
        spi_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
        spi_bits(8'h11, 4, rx);
        spi_end();
        check("t4_partial_we", we_q.size(), 32'd0);
        spi_begin();
        spi_byte(8'h02, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h40, rx);
        spi_byte(8'h11, rx);
        spi_end();
        check("t4_we_count", we_q.size(), 32'd1);
        check("t4_we0", we_at(0), {1'b0, 23'h40, 8'h11});

        // 5: bad command, RDMR, WRMR
        clear_log();
        spi_begin();
        spi_byte(8'hAB, rx);
        spi_byte(8'hFF, rx); check("t5_ignore_so", {24'd0, rx}, 32'h00);
        spi_end();
        check("t5_cmd_err", err_cnt, 32'd1);
        check("t5_strobes", re_q.size() + we_q.size(), 32'd0);
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx); check("t5_rdmr0", {24'd0, rx}, 32'h40);
        spi_byte(8'h00, rx); check("t5_rdmr1", {24'd0, rx}, 32'h40);
        spi_end();
        spi_begin();
        spi_byte(8'h01, rx); spi_byte(8'h00, rx); spi_byte(8'hFF, rx);
        spi_end();
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx); check("t5_rdmr_new", {24'd0, rx}, 32'h00);
        spi_end();
        check("t5_no_err", err_cnt, 32'd1);

        // 6: reset in the middle of a read byte
        clear_log();
        spi_begin();
        spi_byte(8'h03, rx); spi_byte(8'h00, rx); spi_byte(8'h00, rx); spi_byte(8'h20, rx);
        spi_bits(8'h00, 3, rx);
        wait_clk(6);
        check("t6_pre_so", {31'd0, so}, 32'd1);
        reset = 1'b1;
        wait_clk(1);
        check("t6_so",     {31'd0, so},     32'd0);
        check("t6_re",     {31'd0, mem_re}, 32'd0);
        check("t6_we",     {31'd0, mem_we}, 32'd0);
        check("t6_active", {31'd0, active}, 32'd0);
        wait_clk(2);
        reset = 1'b0;
        clear_log();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx);
        check("t6_stale_so", {24'd0, rx}, 32'h00);
        check("t6_stale_active", {31'd0, active}, 32'd0);
        check("t6_stale_strobes", re_q.size() + we_q.size(), 32'd0);
        ce = 1'b1;
        wait_clk(8);
        spi_begin();
        spi_byte(8'h05, rx);
        spi_byte(8'h00, rx); check("t6_rdmr", {24'd0, rx}, 32'h40);
        spi_end();

        check("never_re_and_we", both_cnt, 32'd0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
